mux_4_2: RTL and testbench

- Registered 4-to-1 bit selector: picks one of four data bits by a 2-bit select and presents it on a single-bit output.
- Used as a small datapath/control steering element wherever one status or data bit must be chosen from four sources.
- One clock domain, synchronous active-high reset, one-cycle output latency.

---
 rtl/mux_4_2_if.sv | 19 +
 rtl/mux_4_2.sv | 38 +++
 tb/tb_mux_4_2.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/mux_4_2_if.sv
// Bus bundle for the registered 4-to-1 bit selector: data sources, select code
// and the registered selected bit.
interface mux_4_2_if;
    logic [3:0] data_in;
    logic [1:0] sel;
    logic       y;

    modport master (
        output data_in,
        output sel,
        input  y
    );

    modport slave (
        input  data_in,
        input  sel,
        output y
    );
endinterface

// File: rtl/mux_4_2.sv
// Registered 4-to-1 bit selector: y takes data_in[sel] on every rising edge,
// or RESET_VAL on edges where rst is high. One cycle of latency, no enable.
module mux_4_2 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    mux_4_2_if.slave   bus
);

    logic [3:0] sel_onehot;
    logic       y_next;
    logic       y_reg;

    // Decode the select into one-hot lanes and AND-OR the data bits; an X on
    // sel propagates X through the decode rather than holding any state.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_decode
            assign sel_onehot[gi] = (bus.sel == gi[1:0]);
        end
    endgenerate

    always_comb begin
        y_next = |(sel_onehot & bus.data_in);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_reg <= RESET_VAL;
        end else begin
            y_reg <= y_next;
        end
    end

    assign bus.y = y_reg;

endmodule

// File: tb/tb_mux_4_2.sv
// Scoreboard bench for mux_4_2: stimulus pushes the expected y after each
// rising edge, a negedge monitor pops and compares against the DUT.
module tb_mux_4_2;

    logic clk;
    logic rst;

    mux_4_2_if bus ();

    mux_4_2 #(.RESET_VAL(1'b0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic  exp_y;
        string name;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    bit   done   = 1'b0;

    // Monitor: y is valid every cycle, so one expected entry is consumed per edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (bus.y !== e.exp_y) begin
                errors++;
                $display("FAIL %s: y=%b required=%b", e.name, bus.y, e.exp_y);
            end else begin
                $display("ok   %s: y=%b", e.name, bus.y);
            end
        end
    end

    // Called just after a negedge; drives inputs, records the expectation after
    // the rising edge, returns just after the following negedge.
    task automatic drive(input logic r, input logic [3:0] d, input logic [1:0] s,
                         input logic e, input string name);
        exp_t ent;
        rst         = r;
        bus.data_in = d;
        bus.sel     = s;
        @(posedge clk);
        ent.exp_y = e;
        ent.name  = name;
        exp_q.push_back(ent);
        @(negedge clk);
        #1;
    endtask

    task automatic direct_check(input logic e, input string name);
        checks++;
        if (bus.y !== e) begin
            errors++;
            $display("FAIL %s: y=%b required=%b", name, bus.y, e);
        end else begin
            $display("ok   %s: y=%b", name, bus.y);
        end
    endtask

    logic [3:0] onehot_exp;
    logic [3:0] dv;

    initial begin
        rst         = 1'b1;
        bus.data_in = 4'b0000;
        bus.sel     = 2'b00;
        @(negedge clk);
        #1;

        // Reset holds y low regardless of inputs, release captures immediately.
        drive(1'b1, 4'b1111, 2'b11, 1'b0, "reset_edge1");
        drive(1'b1, 4'b1111, 2'b11, 1'b0, "reset_edge2");
        drive(1'b0, 4'b1111, 2'b11, 1'b1, "reset_release");

        // Exhaustive sweep with a single-edge reset injected midway.
        for (int d = 0; d < 16; d++) begin
            for (int s = 0; s < 4; s++) begin
                if (d == 8 && s == 0)
                    drive(1'b1, 4'b1111, 2'b11, 1'b0, "midrun_reset");
                dv = d[3:0];
                drive(1'b0, dv, s[1:0], dv[s],
                      $sformatf("sweep d=%0d s=%0d", d, s));
            end
        end

        // One-hot walk: data 0100, sel 0..3 -> 0,0,1,0.
        onehot_exp = 4'b0100;
        drive(1'b0, 4'b0100, 2'b00, 1'b0, "onehot s=0");
        drive(1'b0, 4'b0100, 2'b01, 1'b0, "onehot s=1");
        drive(1'b0, 4'b0100, 2'b10, 1'b1, "onehot s=2");
        drive(1'b0, 4'b0100, 2'b11, 1'b0, "onehot s=3");

        // Fixed select, toggling data: 1,0,1,0.
        drive(1'b0, 4'b0010, 2'b01, 1'b1, "toggle 0010");
        drive(1'b0, 4'b1101, 2'b01, 1'b0, "toggle 1101");
        drive(1'b0, 4'b0010, 2'b01, 1'b1, "toggle 0010b");
        drive(1'b0, 4'b1101, 2'b01, 1'b0, "toggle 1101b");

        // Latency: sel changes between edges must not reach y.
        drive(1'b0, 4'b0001, 2'b00, 1'b1, "latency base");
        bus.sel = 2'b01;
        #1;
        direct_check(1'b1, "latency hold sel=1");
        bus.sel = 2'b10;
        #1;
        direct_check(1'b1, "latency hold sel=2");
        drive(1'b0, 4'b0001, 2'b10, 1'b0, "latency update");

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending=%0d required=0", exp_q.size());
        end
        done = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        if (!done) begin
            $display("FAIL watchdog: time=%0t required=finished", $time);
            $fatal(1, "watchdog");
        end
    end

endmodule
